// File: rtl/sm_uart_hex_tx.sv
// UART hex dumper: sends a 32-bit word as uppercase ASCII hex followed by CR LF.
// Define SM_UART_TX_PARITY_EN to add an even-parity bit to each frame (8E1).
module sm_uart_hex_tx #(
    parameter int BAUD_DIV = 434,
    parameter int NDIGITS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic        txd
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0] LAST_CHAR = 4'(NDIGITS + 1);
    localparam logic [3:0] CR_CHAR = 4'(NDIGITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    idx_q, idx_d;
    logic [31:0]   data_q, data_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [3:0] nib;
    logic [7:0] cur_char;
    logic       baud_wrap;
    int         shamt;

    // Character selected by idx_q: hex digits MS nibble first, then CR, then LF.
    always_comb begin
        shamt = 0;
        if (idx_q < CR_CHAR) begin
            shamt = 4 * (NDIGITS - 1 - int'(idx_q));
        end
        nib = 4'(data_q >> shamt);
        if (idx_q == CR_CHAR) begin
            cur_char = 8'h0D;
        end else if (idx_q == LAST_CHAR) begin
            cur_char = 8'h0A;
        end else if (nib < 4'd10) begin
            cur_char = 8'h30 + {4'h0, nib};
        end else begin
            cur_char = 8'h37 + {4'h0, nib};
        end
    end

    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        data_d  = data_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q != S_IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (start) begin
                    data_d  = data;
                    idx_d   = '0;
                    bit_d   = '0;
                    state_d = S_START;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    txd_d   = cur_char[0];
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
`ifdef SM_UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = ^cur_char;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = cur_char[3'(bit_q + 3'd1)];
                    end
                end
            end
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_wrap) begin
                    if (idx_q == LAST_CHAR) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_START;
                        txd_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
